// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser, optional stability filter,
// mode-selected edge pulse, sticky flag and saturating event counter.
module edge_detect_multi #(
    parameter int CH            = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         signal,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH-1:0]         sticky_clr,
    input  logic [CH-1:0]         cnt_clr,
    output logic [CH-1:0]         level,
    output logic [CH-1:0]         event_pulse,
    output logic [CH-1:0]         event_sticky,
    output logic                  any_event,
    output logic [CH*CNT_W-1:0]   edge_cnt
);

    localparam int              FW      = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [FW-1:0]   F_MAX   = FW'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [FW-1:0]          fcnt;
        logic                   level_q;
        logic                   pulse_q;
        logic                   sticky_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   sync_out;
        logic                   accept;
        logic                   match;
        logic [1:0]             ch_mode;

        assign sync_out = sync_q[SYNC_STAGES-1];
        assign ch_mode  = mode[2*i +: 2];
        // fcnt never exceeds F_MAX: reaching it while still different forces acceptance
        assign accept   = (sync_out != level_q) && (fcnt == F_MAX);
        assign match    = sync_out ? ch_mode[0] : ch_mode[1];

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q   <= '0;
                fcnt     <= '0;
                level_q  <= 1'b0;
                pulse_q  <= 1'b0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                // NOTE: non-blocking assignments throughout, so every stage reads its pre-edge neighbour.
                sync_q[0] <= signal[i];
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end

                if (sync_out == level_q) begin
                    fcnt <= '0;
                end else if (accept) begin
                    level_q <= sync_out;
                    fcnt    <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end

                pulse_q <= accept & match;

                // set wins over clear
                if (pulse_q) begin
                    sticky_q <= 1'b1;
                end else if (sticky_clr[i]) begin
                    sticky_q <= 1'b0;
                end

                if (cnt_clr[i]) begin
                    cnt_q <= pulse_q ? CNT_W'(1) : '0;
                end else if (pulse_q && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign level[i]                    = level_q;
        assign event_pulse[i]              = pulse_q;
        assign event_sticky[i]             = sticky_q;
        assign edge_cnt[i*CNT_W +: CNT_W]  = cnt_q;
    end

    assign any_event = |event_pulse;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench: two edge_detect_multi configurations share one stimulus stream and are
// checked cycle by cycle against a reference model built from delay, stability and counting rules.
module tb_edge_detect_multi;

    localparam int CH = 4;
    localparam int WA = 8;
    localparam int WB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     signal;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     sticky_clr;
    logic [CH-1:0]     cnt_clr;

    logic [CH-1:0]     level_a, pulse_a, sticky_a;
    logic              any_a;
    logic [CH*WA-1:0]  cnt_a;
    logic [CH-1:0]     level_b, pulse_b, sticky_b;
    logic              any_b;
    logic [CH*WB-1:0]  cnt_b;

    always #5 clk = ~clk;

    edge_detect_multi #(.CH(CH), .SYNC_STAGES(2), .FILTER_CYCLES(0), .CNT_W(WA)) u_a (
        .clk(clk), .rst(rst), .signal(signal), .mode(mode),
        .sticky_clr(sticky_clr), .cnt_clr(cnt_clr),
        .level(level_a), .event_pulse(pulse_a), .event_sticky(sticky_a),
        .any_event(any_a), .edge_cnt(cnt_a)
    );

    edge_detect_multi #(.CH(CH), .SYNC_STAGES(3), .FILTER_CYCLES(3), .CNT_W(WB)) u_b (
        .clk(clk), .rst(rst), .signal(signal), .mode(mode),
        .sticky_clr(sticky_clr), .cnt_clr(cnt_clr),
        .level(level_b), .event_pulse(pulse_b), .event_sticky(sticky_b),
        .any_event(any_b), .edge_cnt(cnt_b)
    );

    typedef struct packed {
        logic [CH-1:0]      level;
        logic [CH-1:0]      pulse;
        logic [CH-1:0]      sticky;
        logic               any;
        logic [CH-1:0][7:0] cnt;
    } obs_t;

    obs_t exp_a[$];
    obs_t exp_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // configuration of the two instances: sync depth, filter length, count ceiling
    int sp[2]   = '{2, 3};
    int fp[2]   = '{0, 3};
    int cmax[2] = '{255, 15};

    // reference model: raw samples indexed by edge number since reset
    logic [CH-1:0] hist [8];
    int            cyc;
    logic [CH-1:0] m_lvl [2];
    logic [CH-1:0] m_pulse [2];
    logic [CH-1:0] m_sticky [2];
    int            m_run [2][CH];
    int            m_cnt [2][CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        obs_t o;
        if (rst) begin
            cyc = 0;
            for (int d = 0; d < 2; d++) begin
                m_lvl[d] = '0; m_pulse[d] = '0; m_sticky[d] = '0;
                for (int i = 0; i < CH; i++) begin
                    m_run[d][i] = 0;
                    m_cnt[d][i] = 0;
                end
            end
        end else begin
            cyc++;
            hist[cyc % 8] = signal;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < CH; i++) begin
                    int   src;
                    logic so;
                    logic acc;
                    // the synchronised view lags the raw input by the chain depth
                    src = cyc - sp[d];
                    so  = (src >= 1) ? hist[src % 8][i] : 1'b0;
                    acc = 1'b0;
                    if (cnt_clr[i])
                        m_cnt[d][i] = m_pulse[d][i] ? 1 : 0;
                    else if (m_pulse[d][i] && m_cnt[d][i] < cmax[d])
                        m_cnt[d][i] = m_cnt[d][i] + 1;
                    if (m_pulse[d][i])
                        m_sticky[d][i] = 1'b1;
                    else if (sticky_clr[i])
                        m_sticky[d][i] = 1'b0;
                    if (so == m_lvl[d][i]) begin
                        m_run[d][i] = 0;
                    end else if (m_run[d][i] == fp[d]) begin
                        m_lvl[d][i] = so;
                        m_run[d][i] = 0;
                        acc = 1'b1;
                    end else begin
                        m_run[d][i] = m_run[d][i] + 1;
                    end
                    m_pulse[d][i] = acc && (so ? mode[2*i] : mode[2*i+1]);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            o.level  = m_lvl[d];
            o.pulse  = m_pulse[d];
            o.sticky = m_sticky[d];
            o.any    = |m_pulse[d];
            for (int i = 0; i < CH; i++) o.cnt[i] = 8'(m_cnt[d][i]);
            if (d == 0) exp_a.push_back(o);
            else        exp_b.push_back(o);
        end
    endtask

    function automatic obs_t actual(input int d);
        obs_t o;
        o.level  = (d == 0) ? level_a  : level_b;
        o.pulse  = (d == 0) ? pulse_a  : pulse_b;
        o.sticky = (d == 0) ? sticky_a : sticky_b;
        o.any    = (d == 0) ? any_a    : any_b;
        for (int i = 0; i < CH; i++)
            o.cnt[i] = (d == 0) ? cnt_a[i*WA +: WA] : 8'(cnt_b[i*WB +: WB]);
        return o;
    endfunction

    task automatic compare(input string tag, input obs_t e, input obs_t a);
        check({tag, ".level"},  32'(a.level),  32'(e.level));
        check({tag, ".pulse"},  32'(a.pulse),  32'(e.pulse));
        check({tag, ".sticky"}, 32'(a.sticky), 32'(e.sticky));
        check({tag, ".any"},    32'(a.any),    32'(e.any));
        for (int i = 0; i < CH; i++)
            check($sformatf("%s.cnt%0d", tag, i), 32'(a.cnt[i]), 32'(e.cnt[i]));
    endtask

    // monitor: every edge the DUTs present a new output state; pop and compare it
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                compare("a", e, actual(0));
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                compare("b", e, actual(1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; signal = '0; mode = 8'h55; sticky_clr = '0; cnt_clr = '0;
        #2;
        repeat (3) tick();
        check("reset.level_a", 32'(level_a), 32'h0);
        check("reset.cnt_b",   32'(cnt_b),   32'h0);
        rst = 1'b0;

        // ch0 rising in mode 01, then falling gives nothing
        repeat (2) tick();
        signal[0] = 1'b1;
        repeat (10) tick();
        signal[0] = 1'b0;
        repeat (10) tick();
        check("dir.ch0_cnt_a", 32'(cnt_a[0 +: WA]), 32'd1);

        // ch1 square wave, both edges then falling only
        mode = 8'h5D;
        cnt_clr[1] = 1'b1; tick(); cnt_clr[1] = 1'b0;
        for (int k = 0; k < 50; k++) begin
            signal[1] = ((k / 5) % 2 == 0);
            tick();
        end
        signal[1] = 1'b0;
        repeat (10) tick();
        check("dir.sq_both_a", 32'(cnt_a[1*WA +: WA]), 32'd10);
        check("dir.sq_both_b", 32'(cnt_b[1*WB +: WB]), 32'd10);
        mode = 8'h59;
        cnt_clr[1] = 1'b1; tick(); cnt_clr[1] = 1'b0;
        for (int k = 0; k < 50; k++) begin
            signal[1] = ((k / 5) % 2 == 0);
            tick();
        end
        signal[1] = 1'b0;
        repeat (10) tick();
        check("dir.sq_fall_a", 32'(cnt_a[1*WA +: WA]), 32'd5);
        check("dir.sq_fall_b", 32'(cnt_b[1*WB +: WB]), 32'd5);

        // ch2 glitches of 1..5 cycles; the filtered instance accepts only 4 and 5
        for (int len = 1; len <= 5; len++) begin
            signal[2] = 1'b1;
            repeat (len) tick();
            signal[2] = 1'b0;
            repeat (12) tick();
        end
        check("dir.glitch_a", 32'(cnt_a[2*WA +: WA]), 32'd5);
        check("dir.glitch_b", 32'(cnt_b[2*WB +: WB]), 32'd2);

        // ch3 24 edges: filtered 4-bit counter saturates
        mode = 8'hD9;
        for (int k = 0; k < 96; k++) begin
            signal[3] = ((k / 4) % 2 == 0);
            tick();
        end
        signal[3] = 1'b0;
        repeat (12) tick();
        check("dir.sat_a", 32'(cnt_a[3*WA +: WA]), 32'd24);
        check("dir.sat_b", 32'(cnt_b[3*WB +: WB]), 32'd15);

        // fast toggle with clears landing on pulses
        for (int k = 0; k < 20; k++) begin
            signal[3] = ~signal[3];
            cnt_clr[3] = (k == 10);
            sticky_clr[3] = (k == 12);
            tick();
        end
        cnt_clr = '0; sticky_clr = '0;
        signal[3] = 1'b0;
        repeat (12) tick();
        sticky_clr = 4'hF; tick(); sticky_clr = '0; tick();
        check("dir.sticky_clr_a", 32'(sticky_a), 32'h0);

        // input high through reset
        signal = 4'hF; rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        repeat (12) tick();
        check("dir.rst_hi_sticky_a", 32'(sticky_a), 32'hD);
        check("dir.rst_hi_sticky_b", 32'(sticky_b), 32'hD);

        // reset in the middle of a filtered falling edge
        signal = '0;
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (12) tick();
        check("dir.rst_mid_level_b", 32'(level_b), 32'h0);
        check("dir.rst_mid_cnt_b",   32'(cnt_b),   32'h0);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 4) == 0) signal[i] = ~signal[i];
                sticky_clr[i] = ($urandom_range(0, 7) == 0);
                cnt_clr[i]    = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; sticky_clr = '0; cnt_clr = '0;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
